// File: rtl/master_bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding, default
// watchdog length and the tie-break rule.
package master_bus_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_BUSY_A = 2'd1;
  localparam arb_state_t ARB_BUSY_B = 2'd2;

  localparam int unsigned ARB_DEFAULT_TIMEOUT = 64;

  // A wins when it is the only requester, or on a tie when A has priority or B owned last.
  function automatic logic arb_pick_a(input logic req_a, input logic req_b,
                                      input logic prio_a, input logic last_owner_a);
    return req_a && (!req_b || prio_a || !last_owner_a);
  endfunction

endpackage

// File: rtl/master_bus_arbiter_bus_watchdog.sv
// Transaction watchdog: counts BUSY cycles and flags the cycle on which the
// slave has run out of time. TIMEOUT_CYCLES of zero disables it.
module master_bus_arbiter_bus_watchdog
  import master_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] Limit =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic WdogOn = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      // Saturate rather than wrap; the timeout fires long before this matters.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = WdogOn && enable_i && (cnt_q == Limit);

endmodule

// File: rtl/master_bus_arbiter.sv
// Two-master arbiter (A = fetch, B = load/store) for the shared memory bus.
// Owns the bus for a whole transaction and aborts it if the slave never acks.
module master_bus_arbiter
  import master_bus_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_A     = 0,
  parameter int unsigned TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic reqA,
  input  logic reqB,
  output logic grantA,
  output logic grantB,
  output logic doneA,
  output logic doneB,
  output logic errA,
  output logic errB,
  output logic useA,
  output logic slaveReq,
  input  logic slaveAck
);

  localparam logic PrioA = (PRIORITY_A != 0);

  arb_state_t state_q, state_d;
  logic       last_owner_a_q, last_owner_a_d;
  logic       use_a_q, use_a_d;

  logic busy_a, busy_b, busy;
  logic expired;
  logic finish;

  assign busy_a = (state_q == ARB_BUSY_A);
  assign busy_b = (state_q == ARB_BUSY_B);
  assign busy   = busy_a || busy_b;

  // Completion is suppressed while reset is asserted so a reset never emits a done pulse.
  assign finish = busy && !rst && (slaveAck || expired);

  master_bus_arbiter_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (finish),
    .enable_i  (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d        = state_q;
    last_owner_a_d = last_owner_a_q;
    use_a_d        = use_a_q;
    case (state_q)
      ARB_IDLE: begin
        if (reqA || reqB) begin
          if (arb_pick_a(reqA, reqB, PrioA, last_owner_a_q)) begin
            state_d = ARB_BUSY_A;
            use_a_d = 1'b1;
          end else begin
            state_d = ARB_BUSY_B;
            use_a_d = 1'b0;
          end
        end
      end
      ARB_BUSY_A, ARB_BUSY_B: begin
        if (finish) begin
          state_d        = ARB_IDLE;
          last_owner_a_d = busy_a;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      last_owner_a_q <= 1'b0;
      use_a_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      last_owner_a_q <= last_owner_a_d;
      use_a_q        <= use_a_d;
    end
  end

  assign grantA   = busy_a;
  assign grantB   = busy_b;
  assign slaveReq = busy;
  assign useA     = use_a_q;
  assign doneA    = busy_a && finish;
  assign doneB    = busy_b && finish;
  assign errA     = doneA && !slaveAck;
  assign errB     = doneB && !slaveAck;

endmodule

// File: tb/tb_master_bus_arbiter.sv
// Bench for master_bus_arbiter: a round-robin/timeout-4 instance and a
// priority-A/timeout-6 instance driven with shared stimulus, checked against a transaction model.
module tb_master_bus_arbiter;

  localparam int unsigned Prio0 = 0;
  localparam int unsigned Prio1 = 1;
  localparam int unsigned Tmo0  = 4;
  localparam int unsigned Tmo1  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, reqA, reqB, slaveAck;
  logic [1:0] ga, gb, da, db, ea, eb, ua, sr;

  master_bus_arbiter #(
    .PRIORITY_A     (Prio0),
    .TIMEOUT_CYCLES (Tmo0),
    .CNT_W          (8)
  ) dut0 (
    .clk (clk), .rst (rst), .reqA (reqA), .reqB (reqB),
    .grantA (ga[0]), .grantB (gb[0]), .doneA (da[0]), .doneB (db[0]),
    .errA (ea[0]), .errB (eb[0]), .useA (ua[0]), .slaveReq (sr[0]), .slaveAck (slaveAck)
  );

  master_bus_arbiter #(
    .PRIORITY_A     (Prio1),
    .TIMEOUT_CYCLES (Tmo1),
    .CNT_W          (8)
  ) dut1 (
    .clk (clk), .rst (rst), .reqA (reqA), .reqB (reqB),
    .grantA (ga[1]), .grantB (gb[1]), .doneA (da[1]), .doneB (db[1]),
    .errA (ea[1]), .errB (eb[1]), .useA (ua[1]), .slaveReq (sr[1]), .slaveAck (slaveAck)
  );

  // Transaction model: owner 0 = nobody, 1 = A, 2 = B; age = BUSY cycles so far.
  int         m_own [2];
  int         m_age [2];
  bit         m_last_a [2];
  bit         m_use_a [2];
  logic [7:0] exp_v [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [7:0] obs(input int d);
    return {ga[d], gb[d], da[d], db[d], ea[d], eb[d], ua[d], sr[d]};
  endfunction

  function automatic bit timed_out(input int d);
    int unsigned tmo;
    tmo = (d == 0) ? Tmo0 : Tmo1;
    return (m_own[d] != 0) && (tmo != 0) && (m_age[d] == int'(tmo) - 1);
  endfunction

  function automatic bit prio_a(input int d);
    return ((d == 0) ? Prio0 : Prio1) != 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = 0; m_age[d] = 0; m_last_a[d] = 1'b0; m_use_a[d] = 1'b1;
    end
  endtask

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      bit done, err;
      done = !rst && (m_own[d] != 0) && (slaveAck || timed_out(d));
      err  = done && !slaveAck;
      exp_v[d] = {m_own[d] == 1, m_own[d] == 2, done && m_own[d] == 1, done && m_own[d] == 2,
                  err && m_own[d] == 1, err && m_own[d] == 2, m_use_a[d], m_own[d] != 0};
    end
  endtask

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_own[d] = 0; m_age[d] = 0; m_last_a[d] = 1'b0; m_use_a[d] = 1'b1;
      end else if (m_own[d] == 0) begin
        int win;
        if (reqA && reqB) win = (prio_a(d) || !m_last_a[d]) ? 1 : 2;
        else if (reqA)    win = 1;
        else if (reqB)    win = 2;
        else              win = 0;
        if (win != 0) begin
          m_own[d] = win; m_age[d] = 0; m_use_a[d] = (win == 1);
        end
      end else if (slaveAck || timed_out(d)) begin
        m_last_a[d] = (m_own[d] == 1);
        m_own[d] = 0; m_age[d] = 0;
      end else begin
        m_age[d]++;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; reqA = 1'b0; reqB = 1'b0; slaveAck = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reqA = 1'b1; reqB = 1'b1; slaveAck = 1'b0;
    model_reset();
    tick();
    for (int c = 0; c < 4; c++) begin
      rst      = (c == 0);
      slaveAck = (c == 2);
      reqA     = (c < 2);
      reqB     = (c < 2);
      sample();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs(d) !== exp_v[d])
          $display("FAIL reset_model dut%0d c%0d got=%b want=%b", d, c, obs(d), exp_v[d]);
        else n_pass++;
        n_chk++;
        if (c == 0 && obs(d) !== 8'b0000_0010)
          $display("FAIL reset_outputs dut%0d got=%b want=00000010", d, obs(d));
        else if (c == 2 && {ga[d], gb[d], ua[d]} !== 3'b101)
          $display("FAIL reset_first_grant dut%0d got=%b want=101", d, {ga[d], gb[d], ua[d]});
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_single_b();
    logic [2:0] want;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      reqB = (c <= 3); slaveAck = (c == 3);
      sample();
      want = (c >= 1 && c <= 3) ? {1'b1, c == 3, 1'b1} : 3'b000;
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs(d) !== exp_v[d])
          $display("FAIL single_b_model dut%0d c%0d got=%b want=%b", d, c, obs(d), exp_v[d]);
        else n_pass++;
        n_chk++;
        if ({gb[d], db[d], sr[d]} !== want || (c >= 1 && ua[d] !== 1'b0))
          $display("FAIL single_b dut%0d c%0d got gb/db/sr/ua=%b%b want=%b0", d, c,
                   {gb[d], db[d], sr[d]}, ua[d], want);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    string seq [2];
    logic  prev [2];
    do_reset();
    seq[0] = ""; seq[1] = ""; prev[0] = 1'b0; prev[1] = 1'b0;
    for (int c = 0; c < 18; c++) begin
      reqA = (c < 16); reqB = (c < 16);
      slaveAck = (m_own[0] != 0) && (m_age[0] == 2);
      sample();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs(d) !== exp_v[d])
          $display("FAIL rr_model dut%0d c%0d got=%b want=%b", d, c, obs(d), exp_v[d]);
        else n_pass++;
        if ((ga[d] || gb[d]) && !prev[d]) seq[d] = {seq[d], ga[d] ? "A" : "B"};
        prev[d] = ga[d] || gb[d];
      end
      tick();
    end
    n_chk++;
    if (seq[0] != "ABAB") $display("FAIL rr_order got=%s want=ABAB", seq[0]);
    else n_pass++;
    n_chk++;
    if (seq[1] != "AAAA") $display("FAIL prio_order got=%s want=AAAA", seq[1]);
    else n_pass++;
    slaveAck = 1'b0;
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int c = 0; c < 9; c++) begin
        reqA = (c <= 4);
        slaveAck = (pass == 1) && (c == 4);
        sample();
        for (int d = 0; d < 2; d++) begin
          n_chk++;
          if (obs(d) !== exp_v[d])
            $display("FAIL timeout_model p%0d dut%0d c%0d got=%b want=%b", pass, d, c, obs(d),
                     exp_v[d]);
          else n_pass++;
        end
        n_chk++;
        if (c == 4 && {da[0], ea[0]} !== ((pass == 0) ? 2'b11 : 2'b10))
          $display("FAIL timeout_done p%0d got done/err=%b want=%b", pass, {da[0], ea[0]},
                   (pass == 0) ? 2'b11 : 2'b10);
        else if (c == 5 && (ga[0] !== 1'b0 || sr[0] !== 1'b0))
          $display("FAIL timeout_idle p%0d got grant/req=%b%b want=00", pass, ga[0], sr[0]);
        else if (pass == 0 && c == 6 && {da[1], ea[1]} !== 2'b11)
          $display("FAIL timeout_long got done/err=%b want=11", {da[1], ea[1]});
        else n_pass++;
        tick();
      end
    end
    slaveAck = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      reqB = (c <= 2); reqA = (c >= 2) && (c <= 4);
      rst = (c == 2); slaveAck = (c == 2) || (c == 5);
      sample();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs(d) !== exp_v[d])
          $display("FAIL rst_busy_model dut%0d c%0d got=%b want=%b", d, c, obs(d), exp_v[d]);
        else n_pass++;
        n_chk++;
        if (c == 2 && {gb[d], db[d], eb[d]} !== 3'b100)
          $display("FAIL rst_busy_nodone dut%0d got gb/db/eb=%b want=100", d,
                   {gb[d], db[d], eb[d]});
        else if (c == 3 && {ga[d], gb[d]} !== 2'b00)
          $display("FAIL rst_busy_idle dut%0d got=%b want=00", d, {ga[d], gb[d]});
        else if (c == 4 && ga[d] !== 1'b1)
          $display("FAIL rst_busy_grant_a dut%0d got=%b want=1", d, ga[d]);
        else n_pass++;
      end
      tick();
    end
    rst = 1'b0; slaveAck = 1'b0; reqA = 1'b0; reqB = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(63) == 0);
      reqA     = ($urandom_range(2) != 0);
      reqB     = ($urandom_range(2) != 0);
      slaveAck = ($urandom_range(4) == 0);
      sample();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs(d) !== exp_v[d])
          $display("FAIL random_model dut%0d c%0d got=%b want=%b", d, c, obs(d), exp_v[d]);
        else n_pass++;
        n_chk++;
        if ((ga[d] & gb[d]) !== 1'b0)
          $display("FAIL random_exclusive dut%0d c%0d got grants=%b%b want one-hot-or-zero",
                   d, c, ga[d], gb[d]);
        else n_pass++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_b();
    test_round_robin();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
